rggen_register_initiator: RTL

RGGEN_REGISTER_INITIATOR -- requirements
Module: rggen_register_initiator

---
 rtl/rggen_initiator_pkg.sv | 36 +++
 rtl/rggen_initiator_timeout.sv | 45 ++++
 rtl/rggen_register_initiator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rggen_initiator_pkg.sv
// rtl/rggen_initiator_pkg.sv - shared encodings and helpers for the register initiator
//
// Purpose: access/status encodings, FSM state type and the clog2 helper
// shared by rggen_register_initiator and rggen_initiator_timeout.
// Ports: none (package).

package rggen_initiator_pkg;

    localparam logic [1:0] ACCESS_READ  = 2'b10;
    localparam logic [1:0] ACCESS_WRITE = 2'b11;
    localparam int         ACCESS_WRITE_BIT = 0;

    localparam logic [1:0] STATUS_OKAY         = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
    localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE     = 2'b00,
        STATE_REQUEST  = 2'b01,
        STATE_RESPONSE = 2'b10
    } initiator_state_e;

    // Smallest n with 2**n >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rggen_initiator_timeout.sv
// rtl/rggen_initiator_timeout.sv - request wait-cycle counter with expiry flag
//
// Purpose: counts cycles while enable is high; expired is raised in the cycle
// that would make the count reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 never expires.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-high reset
//   clear   in  synchronous counter clear
//   enable  in  count this cycle
//   expired out combinational expiry for the current cycle

module rggen_initiator_timeout
    import rggen_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int RAW_WIDTH = clog2(TIMEOUT_CYCLES + 1);
    localparam int WIDTH     = (RAW_WIDTH < 1) ? 1 : RAW_WIDTH;
    localparam logic [WIDTH-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count;

    // The current cycle is the TIMEOUT_CYCLES-th waiting cycle when the
    // count of earlier waiting cycles equals TIMEOUT_CYCLES-1.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rggen_register_initiator.sv
// rtl/rggen_register_initiator.sv - single-outstanding register access initiator
//
// Purpose: accepts a command, presents it to the register block until ready
// (or timeout), then returns status/read data on the response handshake.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready          command handshake
//   i_cmd_access/address/write_data/strobe  command fields
//   o_register_valid/access/address/write_data/strobe  register-side request
//   i_register_ready/status/read_data  register-side response
//   o_rsp_valid / i_rsp_ready, o_rsp_status, o_rsp_read_data  response handshake

module rggen_register_initiator
    import rggen_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_access,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_register_valid,
    output logic [1:0]               o_register_access,
    output logic [ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]     o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
    input  logic                     i_register_ready,
    input  logic [1:0]               i_register_status,
    input  logic [BUS_WIDTH-1:0]     i_register_read_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int LSB_WIDTH    = clog2(BUS_WIDTH) - 3;
    // Clears the byte-offset bits so the request is bus-word aligned.
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
        ~((ADDRESS_WIDTH'(1) << LSB_WIDTH) - ADDRESS_WIDTH'(1));

    initiator_state_e state_q;
    initiator_state_e state_d;

    logic                     cmd_accept;
    logic                     in_request;
    logic                     timeout_expired;
    logic [1:0]               access_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [STROBE_WIDTH-1:0]  strobe_q;
    logic [1:0]               rsp_status_q;
    logic [BUS_WIDTH-1:0]     rsp_data_q;

    // Ready is masked during reset so nothing upstream sees a handshake
    // while the state register is held.
    always_comb begin
        o_cmd_ready      = 1'b0;
        o_register_valid = 1'b0;
        o_rsp_valid      = 1'b0;
        in_request       = 1'b0;
        case (state_q)
            STATE_IDLE:     o_cmd_ready = !i_rst;
            STATE_REQUEST: begin
                o_register_valid = 1'b1;
                in_request       = 1'b1;
            end
            STATE_RESPONSE: o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign cmd_accept = i_cmd_valid && o_cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE: begin
                if (cmd_accept) begin
                    state_d = STATE_REQUEST;
                end
            end
            STATE_REQUEST: begin
                if (i_register_ready || timeout_expired) begin
                    state_d = STATE_RESPONSE;
                end
            end
            STATE_RESPONSE: begin
                if (i_rsp_ready) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    rggen_initiator_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (!in_request),
        .enable  (in_request && !i_register_ready),
        .expired (timeout_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            access_q     <= 2'b00;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
        end else if (cmd_accept) begin
            access_q  <= i_cmd_access;
            address_q <= i_cmd_address & ADDRESS_MASK;
            if (i_cmd_access[ACCESS_WRITE_BIT]) begin
                write_data_q <= i_cmd_write_data;
                strobe_q     <= i_cmd_strobe;
            end else begin
                write_data_q <= '0;
                strobe_q     <= '0;
            end
        end
    end

    // Ready wins over timeout: the timeout branch is only taken when ready is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_status_q <= STATUS_OKAY;
            rsp_data_q   <= '0;
        end else if (in_request) begin
            if (i_register_ready) begin
                rsp_status_q <= i_register_status;
                rsp_data_q   <= access_q[ACCESS_WRITE_BIT] ? '0 : i_register_read_data;
            end else if (timeout_expired) begin
                rsp_status_q <= STATUS_SLAVE_ERROR;
                rsp_data_q   <= '0;
            end
        end
    end

    assign o_register_access     = access_q;
    assign o_register_address    = address_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;
    assign o_rsp_status          = rsp_status_q;
    assign o_rsp_read_data       = rsp_data_q;

endmodule
